// File: rtl/operand_fetch.sv
// operand_fetch: read-side operand selection for the A..D register file.
//
// Takes a decode request naming two source registers, selects both operands
// from the register-file outputs (bypassing a same-cycle write-back) and
// presents the pair to the ALU stage through a valid/ready handshake. A
// 2-entry buffer (output entry + skid entry) keeps req_ready free of any
// combinational dependence on op_ready.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready     decode request handshake
//   src_a_sel, src_b_sel    source register selects (00=A 01=B 10=C 11=D)
//   reg_a_in..reg_d_in      current register-file contents
//   wb_enable/select/data   register write happening this cycle
//   op_valid/op_ready       ALU-side handshake
//   operand_a, operand_b    registered operand pair
module operand_fetch #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            src_a_sel,
    input  logic [1:0]            src_b_sel,
    input  logic [DATA_WIDTH-1:0] reg_a_in,
    input  logic [DATA_WIDTH-1:0] reg_b_in,
    input  logic [DATA_WIDTH-1:0] reg_c_in,
    input  logic [DATA_WIDTH-1:0] reg_d_in,
    input  logic                  wb_enable,
    input  logic [1:0]            wb_select,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] operand_a,
    output logic [DATA_WIDTH-1:0] operand_b
);

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_a_q;
    logic [DATA_WIDTH-1:0] out_b_q;
    logic                  skid_valid_q;
    logic [DATA_WIDTH-1:0] skid_a_q;
    logic [DATA_WIDTH-1:0] skid_b_q;

    logic                  acc;
    logic                  drn;
    logic [DATA_WIDTH-1:0] new_a;
    logic [DATA_WIDTH-1:0] new_b;

    // Select one operand; a write to the same register this cycle wins.
    function automatic logic [DATA_WIDTH-1:0] pick(input logic [1:0] sel);
        logic [DATA_WIDTH-1:0] val;
        unique case (sel)
            2'd0:    val = reg_a_in;
            2'd1:    val = reg_b_in;
            2'd2:    val = reg_c_in;
            default: val = reg_d_in;
        endcase
        if (wb_enable && (wb_select == sel)) begin
            val = wb_data;
        end
        return val;
    endfunction

    always_comb begin
        new_a = pick(src_a_sel);
        new_b = pick(src_b_sel);
    end

    // Ready is purely a function of the skid flop.
    assign req_ready = ~skid_valid_q;
    assign acc       = req_valid && req_ready;
    assign drn       = out_valid_q && op_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
        end else if (skid_valid_q) begin
            // Full: only a drain can happen; skid moves forward in order.
            if (drn) begin
                out_a_q      <= skid_a_q;
                out_b_q      <= skid_b_q;
                skid_valid_q <= 1'b0;
                skid_a_q     <= '0;
                skid_b_q     <= '0;
            end
        end else if (!out_valid_q || drn) begin
            // Output entry is empty or being drained: new pair goes straight in.
            out_valid_q <= acc;
            if (acc) begin
                out_a_q <= new_a;
                out_b_q <= new_b;
            end
        end else if (acc) begin
            // Output entry stalled: park the new pair in the skid entry.
            skid_valid_q <= 1'b1;
            skid_a_q     <= new_a;
            skid_b_q     <= new_b;
        end
    end

    assign op_valid  = out_valid_q;
    assign operand_a = out_a_q;
    assign operand_b = out_b_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed scenarios followed by random traffic,
// all checked against a queue-based model of a 2-deep FIFO of operand pairs.
module tb_operand_fetch;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   src_a_sel;
    logic [1:0]   src_b_sel;
    logic         wb_enable;
    logic [1:0]   wb_select;
    logic [W-1:0] wb_data;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;

    logic [W-1:0] regs [4];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    pair_t q[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .src_a_sel (src_a_sel),
        .src_b_sel (src_b_sel),
        .reg_a_in  (regs[0]),
        .reg_b_in  (regs[1]),
        .reg_c_in  (regs[2]),
        .reg_d_in  (regs[3]),
        .wb_enable (wb_enable),
        .wb_select (wb_select),
        .wb_data   (wb_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .operand_a (operand_a),
        .operand_b (operand_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit rv, input logic [1:0] as, input logic [1:0] bs,
                         input bit we, input logic [1:0] ws, input logic [W-1:0] wd,
                         input bit ordy);
        req_valid = rv;
        src_a_sel = as;
        src_b_sel = bs;
        wb_enable = we;
        wb_select = ws;
        wb_data   = wd;
        op_ready  = ordy;
    endtask

    function automatic logic [W-1:0] fetch(input logic [1:0] sel);
        if (wb_enable && wb_select == sel) return wb_data;
        return regs[sel];
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".op_valid"}, {31'd0, op_valid}, {31'd0, q.size() != 0});
        check({tag, ".req_ready"}, {31'd0, req_ready}, {31'd0, q.size() < 2});
        if (q.size() != 0) begin
            check({tag, ".operand_a"}, {16'd0, operand_a}, {16'd0, q[0].a});
            check({tag, ".operand_b"}, {16'd0, operand_b}, {16'd0, q[0].b});
        end
    endtask

    // One clock: inputs are already driven (we sit at a negedge).
    task automatic tick(input string tag);
        bit    acc;
        bit    drn;
        pair_t p;
        acc = req_valid && (q.size() < 2);
        drn = (q.size() != 0) && op_ready;
        p.a = fetch(src_a_sel);
        p.b = fetch(src_b_sel);
        @(negedge clk);
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(p);
        if (wb_enable) regs[wb_select] = wb_data;
        compare_model(tag);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        regs[0] = 16'h1111;
        regs[1] = 16'h2222;
        regs[2] = 16'h3333;
        regs[3] = 16'h4444;

        // Reset state, with a request presented that must be dropped.
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.op_valid", {31'd0, op_valid}, 32'd0);
        check("rst.operand_a", {16'd0, operand_a}, 32'd0);
        check("rst.operand_b", {16'd0, operand_b}, 32'd0);
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        compare_model("post_rst");

        // Basic fetch.
        drive(1, 2'd2, 2'd1, 0, 0, 0, 1);
        tick("basic");
        check("basic.a", {16'd0, operand_a}, 32'h3333);
        check("basic.b", {16'd0, operand_b}, 32'h2222);

        // Bypass, then the same read with no write.
        drive(1, 2'd3, 2'd3, 1, 2'd3, 16'hBEEF, 1);
        tick("bypass");
        check("bypass.a", {16'd0, operand_a}, 32'hBEEF);
        check("bypass.b", {16'd0, operand_b}, 32'hBEEF);
        regs[3] = 16'h4444;
        drive(1, 2'd3, 2'd3, 0, 0, 0, 1);
        tick("nobypass");
        check("nobypass.a", {16'd0, operand_a}, 32'h4444);
        check("nobypass.b", {16'd0, operand_b}, 32'h4444);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick("drain0");

        // Backpressure: R1, R2 fill the buffer, R3 is held off.
        drive(1, 2'd0, 2'd1, 0, 0, 0, 0);
        tick("bp.r1");
        drive(1, 2'd2, 2'd3, 0, 0, 0, 0);
        tick("bp.r2");
        drive(1, 2'd1, 2'd1, 0, 0, 0, 0);
        tick("bp.r3hold");
        check("bp.full_ready", {31'd0, req_ready}, 32'd0);
        check("bp.hold_a", {16'd0, operand_a}, 32'h1111);
        check("bp.hold_b", {16'd0, operand_b}, 32'h2222);
        op_ready = 1'b1;
        tick("bp.d1");
        check("bp.r2_a", {16'd0, operand_a}, 32'h3333);
        check("bp.r2_b", {16'd0, operand_b}, 32'h4444);
        tick("bp.d2");
        check("bp.r3_a", {16'd0, operand_a}, 32'h2222);
        check("bp.r3_b", {16'd0, operand_b}, 32'h2222);
        req_valid = 1'b0;
        tick("bp.d3");
        check("bp.empty", {31'd0, op_valid}, 32'd0);

        // Streaming with rotating selects.
        for (int i = 0; i < 8; i++) begin
            drive(1, 2'(i), 2'(i + 1), 0, 0, 0, 1);
            tick("stream");
            check("stream.valid", {31'd0, op_valid}, 32'd1);
            check("stream.a", {16'd0, operand_a}, {16'd0, regs[i % 4]});
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        tick("drain1");

        // Snapshot: buffered entry ignores a later write.
        drive(1, 2'd0, 2'd0, 0, 0, 0, 0);
        tick("snap.r1");
        drive(0, 0, 0, 1, 2'd0, 16'h5555, 0);
        tick("snap.wr");
        check("snap.hold_a", {16'd0, operand_a}, 32'h1111);
        drive(1, 2'd0, 2'd0, 0, 0, 0, 1);
        tick("snap.r2");
        check("snap.new_a", {16'd0, operand_a}, 32'h5555);

        // Reset mid-run with the buffer full.
        drive(1, 2'd1, 2'd2, 0, 0, 0, 0);
        tick("mr.fill1");
        tick("mr.fill2");
        check("mr.full", {31'd0, req_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("mr.op_valid", {31'd0, op_valid}, 32'd0);
        check("mr.operand_a", {16'd0, operand_a}, 32'h0000);
        check("mr.operand_b", {16'd0, operand_b}, 32'h0000);
        check("mr.req_ready", {31'd0, req_ready}, 32'd1);
        q.delete();
        req_valid = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        compare_model("mr.after");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 3)] = 16'($urandom);
            drive($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom),
                  $urandom_range(0, 1) == 1, 2'($urandom), 16'($urandom),
                  $urandom_range(0, 2) != 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side companion to the gp_registers write port.
- Accepts a decode-stage request naming two source registers (A..D) and selects both operands from the register-file outputs.
- Bypasses a same-cycle register write, so a write and a read on one edge return the new value.
- Presents a registered operand pair to the ALU stage through a valid/ready handshake, backed by a 2-entry skid buffer so decode never stalls combinationally on ALU ready.

Parameters:
- DATA_WIDTH, 16: operand and register width. Must equal the register-file width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  decode request valid.
- req_ready  output  1  request accepted when req_valid && req_ready at a clk rising edge.
- src_a_sel  input  2  source register for operand_a: 00=A, 01=B, 10=C, 11=D.
- src_b_sel  input  2  source register for operand_b, same encoding as src_a_sel.
- reg_a_in, reg_b_in, reg_c_in, reg_d_in  input  DATA_WIDTH each  current register-file contents.
- wb_enable  input  1  register write occurring this cycle; same signal as the register-file write enable.
- wb_select  input  2  register being written.
- wb_data  input  DATA_WIDTH  value being written.
- op_valid  output  1  operand pair valid.
- op_ready  input  1  ALU stage accepts the operand pair when op_valid && op_ready.
- operand_a  output  DATA_WIDTH  first operand.
- operand_b  output  DATA_WIDTH  second operand.

Behaviour:
- Reset: asynchronous and active-high; the single clock is clk. Asserting reset clears both buffer entries immediately, regardless of clock or any transfer in progress.
  - op_valid=0, operand_a=0, operand_b=0, skid entry invalid and zeroed.
  - req_ready is combinational ~skid_valid, so it reads 1 during and after reset.
  - Requests presented while reset is high are dropped.
- Operand select, per source, evaluated at the accept edge:
  - If wb_enable && wb_select==sel, the operand is wb_data (bypass).
  - Otherwise it is the reg_X_in value selected by sel.
  - src_a_sel and src_b_sel may name the same register; both operands then get the same value, including when bypassed.
- Snapshot rule: operands are captured at the accept edge. Later writes do not update a buffered entry.
- Latency: a request accepted at edge N appears on operand_a/operand_b with op_valid=1 after edge N, provided the output entry was empty or drained at N.
- Buffer states:
  - EMPTY: op_valid=0, skid invalid.
  - ONE: op_valid=1, skid invalid.
  - FULL: op_valid=1, skid valid, req_ready=0.
- Transitions (acc = req_valid && req_ready, drn = op_valid && op_ready):
  - EMPTY: acc -> ONE (new pair into the output entry). Otherwise stay EMPTY.
  - ONE: acc && drn -> ONE (output entry replaced by the new pair). acc && !drn -> FULL (new pair into skid). !acc && drn -> EMPTY. Otherwise stay ONE.
  - FULL: drn -> ONE (skid moves to the output entry, skid cleared). No accept is possible while FULL.
- Ordering: strictly FIFO. The output never overtakes the skid entry.
- Output stability: while op_valid && !op_ready, operand_a and operand_b hold stable.
- Outputs come straight from flops. req_ready depends only on internal state, with no combinational path from op_ready.

Test Plan:
- Reset mid-run: buffer FULL, assert reset between edges -> op_valid=0, operands=0000, req_ready=1 immediately.
- Basic fetch: regs A..D = 0x1111/0x2222/0x3333/0x4444; request a_sel=10, b_sel=01, op_ready=1 -> next cycle operand_a=0x3333, operand_b=0x2222, op_valid=1.
- Bypass: same-cycle wb_enable=1, wb_select=11, wb_data=0xBEEF with request a_sel=11, b_sel=11 -> both operands 0xBEEF. Repeat with wb_enable=0 -> both 0x4444.
- Backpressure: op_ready=0, issue requests R1 (A,B) and R2 (C,D), then hold req_valid with R3 -> state FULL, req_ready=0, R3 not accepted, operand_a/operand_b stay 0x1111/0x2222.
  - Release op_ready -> R1 drains, then R2 (0x3333/0x4444), then R3, in order.
- Streaming: req_valid=1 and op_ready=1 every cycle for 8 cycles with rotating selects -> one pair accepted per cycle, op_valid continuously 1 from the cycle after the first accept, no drops or duplicates.
- Snapshot: accept R1 reading A while op_ready=0, then write A=0x5555 -> R1 still presents 0x1111; a request accepted after the write reads 0x5555.
